enemy_move_scheduler: RTL and testbench

- Central timebase and sequencer for the ground-level enemy sprites (mask enemies).
- Replaces the free-running per-sprite tick counters with one shared prescaler. Base ticks are distributed round-robin as single-cycle move enables, one enemy slot per tick.
- Runs a per-enemy IDLE/CHASE/STUN state machine and drives the shared two-frame walk-animation select.
- Sprite modules consume move_en[i] and anim_sel instead of generating their own ticks.

---
 rtl/enemy_move_scheduler.sv | 179 +++++++++++++++++
 tb/tb_enemy_move_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_move_scheduler.sv
// enemy_move_scheduler
// Shared timebase for the ground-level mask enemies. One prescaler produces
// base ticks. Each tick is handed to one enemy slot in turn and becomes a
// single-cycle move strobe, but only if that enemy is chasing. Each enemy has
// an IDLE/CHASE/STUN state machine. The block also drives the shared
// two-frame walk-animation select.
module enemy_move_scheduler #(
  parameter int N_ENEMY    = 4,
  parameter int TIME_MAX   = 4600000,
  parameter int MIN_PERIOD = 2,
  parameter int ANIM_HALF  = 20000000,
  parameter int TRIGGER_Y  = 297,
  parameter int STUN_TICKS = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [25:0]        speed_offset,
  input  logic [9:0]         jojo_y,
  input  logic               pause,
  input  logic [N_ENEMY-1:0] hit,
  output logic [N_ENEMY-1:0] move_en,
  output logic [N_ENEMY-1:0] chase,
  output logic [N_ENEMY-1:0] stunned,
  output logic               anim_sel,
  output logic [2:0]         slot
);

  localparam logic [1:0]  ST_IDLE      = 2'd0;
  localparam logic [1:0]  ST_CHASE     = 2'd1;
  localparam logic [1:0]  ST_STUN      = 2'd2;
  localparam logic [26:0] TIME_MAX_C   = 27'(TIME_MAX);
  localparam logic [26:0] MIN_PERIOD_C = 27'(MIN_PERIOD);
  localparam logic [25:0] ANIM_HALF_C  = 26'(ANIM_HALF);
  localparam logic [25:0] ANIM_LAST_C  = 26'(2 * ANIM_HALF - 1);
  localparam logic [9:0]  TRIGGER_Y_C  = 10'(TRIGGER_Y);
  localparam logic [6:0]  STUN_TICKS_C = 7'(STUN_TICKS);
  localparam logic [2:0]  LAST_SLOT_C  = 3'(N_ENEMY - 1);

  logic [25:0]        presc_q, presc_d;
  logic [25:0]        anim_q, anim_d;
  logic [2:0]         slot_q, slot_d;
  logic [1:0]         state_q [N_ENEMY];
  logic [1:0]         state_d [N_ENEMY];
  logic [6:0]         stun_q [N_ENEMY];
  logic [6:0]         stun_d [N_ENEMY];
  logic [N_ENEMY-1:0] move_en_q, move_en_d;
  logic [N_ENEMY-1:0] chase_q, chase_d;
  logic [N_ENEMY-1:0] stunned_q, stunned_d;
  logic               anim_sel_q, anim_sel_d;
  logic signed [26:0] diff_s;
  logic [25:0]        period_s;
  logic               base_tick_s;
  logic               trig_s;

  assign trig_s = (jojo_y >= TRIGGER_Y_C);

  // Effective tick period: nominal period minus difficulty offset, clamped from below.
  always_comb begin
    diff_s = $signed(TIME_MAX_C) - $signed({1'b0, speed_offset});
    if (diff_s < $signed(MIN_PERIOD_C)) begin
      period_s = MIN_PERIOD_C[25:0];
    end else begin
      period_s = diff_s[25:0];
    end
  end

  // Prescaler and round-robin pointer. A ">=" compare lets a sudden period cut wrap at once.
  always_comb begin
    base_tick_s = !pause && (presc_q >= (period_s - 26'd1));
    presc_d     = presc_q;
    slot_d      = slot_q;
    if (base_tick_s) begin
      presc_d = 26'd0;
      slot_d  = (slot_q == LAST_SLOT_C) ? 3'd0 : (slot_q + 3'd1);
    end else if (!pause) begin
      presc_d = presc_q + 26'd1;
    end else begin
      presc_d = presc_q;
    end
  end

  // Animation counter (held by pause) and frame-row select.
  always_comb begin
    if (pause) begin
      anim_d = anim_q;
    end else if (anim_q >= ANIM_LAST_C) begin
      anim_d = 26'd0;
    end else begin
      anim_d = anim_q + 26'd1;
    end
    anim_sel_d = (anim_q >= ANIM_HALF_C) && trig_s;
  end

  // Per-enemy FSMs, stun counters, move strobe and status decodes.
  always_comb begin
    for (int i = 0; i < N_ENEMY; i++) begin
      state_d[i] = state_q[i];
      stun_d[i]  = stun_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (trig_s) begin
            state_d[i] = ST_CHASE;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_CHASE: begin
          // A hit outranks losing sight of the player.
          if (hit[i]) begin
            state_d[i] = ST_STUN;
            stun_d[i]  = STUN_TICKS_C;
          end else if (!trig_s) begin
            state_d[i] = ST_IDLE;
          end else begin
            state_d[i] = ST_CHASE;
          end
        end
        ST_STUN: begin
          // A fresh hit restarts the window, even on a tick.
          if (hit[i]) begin
            stun_d[i] = STUN_TICKS_C;
          end else if (base_tick_s) begin
            stun_d[i] = stun_q[i] - 7'd1;
            if (stun_q[i] == 7'd1) begin
              state_d[i] = trig_s ? ST_CHASE : ST_IDLE;
            end else begin
              state_d[i] = ST_STUN;
            end
          end else begin
            stun_d[i] = stun_q[i];
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          stun_d[i]  = 7'd0;
        end
      endcase
      move_en_d[i] = base_tick_s && (slot_q == 3'(i)) && (state_q[i] == ST_CHASE);
      chase_d[i]   = (state_d[i] == ST_CHASE);
      stunned_d[i] = (state_d[i] == ST_STUN);
    end
  end

  // State registers; asynchronous reset drops any pending strobe immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= 26'd0;
      anim_q     <= 26'd0;
      slot_q     <= 3'd0;
      move_en_q  <= '0;
      chase_q    <= '0;
      stunned_q  <= '0;
      anim_sel_q <= 1'b0;
      for (int i = 0; i < N_ENEMY; i++) begin
        state_q[i] <= ST_IDLE;
        stun_q[i]  <= 7'd0;
      end
    end else begin
      presc_q    <= presc_d;
      anim_q     <= anim_d;
      slot_q     <= slot_d;
      move_en_q  <= move_en_d;
      chase_q    <= chase_d;
      stunned_q  <= stunned_d;
      anim_sel_q <= anim_sel_d;
      for (int i = 0; i < N_ENEMY; i++) begin
        state_q[i] <= state_d[i];
        stun_q[i]  <= stun_d[i];
      end
    end
  end

  assign move_en  = move_en_q;
  assign chase    = chase_q;
  assign stunned  = stunned_q;
  assign anim_sel = anim_sel_q;
  assign slot     = slot_q;

endmodule

// File: tb/tb_enemy_move_scheduler.sv
// Bench for enemy_move_scheduler with TIME_MAX=10, ANIM_HALF=8, STUN_TICKS=3,
// N_ENEMY=4. Expected move strobes are queued with their due cycle. A monitor
// compares them against move_en on every falling edge. Any cycle with no
// queued entry must show move_en == 0.
module tb_enemy_move_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [25:0] speed_offset = 26'd0;
  logic [9:0]  jojo_y = 10'd300;
  logic        pause = 1'b0;
  logic [3:0]  hit = 4'd0;
  logic [3:0]  move_en;
  logic [3:0]  chase;
  logic [3:0]  stunned;
  logic        anim_sel;
  logic [2:0]  slot;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit sb_on = 1'b0;

  typedef struct {
    int         due;
    logic [3:0] vec;
  } exp_t;
  exp_t sb_q[$];

  enemy_move_scheduler #(
    .N_ENEMY(4), .TIME_MAX(10), .MIN_PERIOD(2), .ANIM_HALF(8),
    .TRIGGER_Y(297), .STUN_TICKS(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .speed_offset(speed_offset), .jojo_y(jojo_y),
    .pause(pause), .hit(hit), .move_en(move_en), .chase(chase),
    .stunned(stunned), .anim_sel(anim_sel), .slot(slot)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [3:0] onehot(input int k);
    logic [3:0] v;
    v = 4'd0;
    v[k % 4] = 1'b1;
    return v;
  endfunction

  task automatic push(input int due, input logic [3:0] vec);
    exp_t e;
    e.due = due;
    e.vec = vec;
    sb_q.push_back(e);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (sb_on) begin
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        chk("move_en", 32'(move_en), 32'(sb_q[0].vec));
        sb_q.delete(0);
      end else begin
        chk("move_idle", 32'(move_en), 32'd0);
      end
    end
  end

  task automatic do_reset(input logic [25:0] off, input logic [9:0] y, output int r);
    sb_on = 1'b0;
    reset_n = 1'b0;
    speed_offset = off;
    jojo_y = y;
    pause = 1'b0;
    hit = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_out", {19'd0, move_en, chase, stunned, anim_sel, slot}, 32'd0);
    reset_n = 1'b1;
    r = cyc;
    sb_q.delete();
    sb_on = 1'b1;
  endtask

  task automatic run_period(input logic [25:0] off, input int p, input string tag);
    int r;
    do_reset(off, 10'd300, r);
    for (int j = 1; j <= 6; j++) push(r + p * j, onehot(j - 1));
    wait_to(r + 6 * p + 1);
    chk(tag, sb_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int r;
    repeat (3) @(negedge clk);

    // Reset release and nominal round-robin
    do_reset(26'd0, 10'd300, r);
    for (int k = 1; k <= 5; k++) push(r + 10 * k, onehot(k - 1));
    for (int c = r + 1; c <= r + 51; c++) begin
      wait_to(c);
      if (c == r + 1) chk("chase_rel", 32'(chase), 32'hF);
      if (c == r + 10) chk("slot_10", 32'(slot), 32'd1);
      if (c <= r + 50) chk("anim_sel", 32'(anim_sel), 32'(((c - r - 1) % 16) >= 8));
    end
    chk("sb_empty_rst", sb_q.size(), 32'd0);

    // Speed clamp
    run_period(26'd20, 2, "sb_empty_p20");
    run_period(26'd8, 2, "sb_empty_p8");
    run_period(26'd7, 3, "sb_empty_p7");

    // Period cut while count already beyond new P-1
    do_reset(26'd0, 10'd300, r);
    push(r + 7, 4'b0001); push(r + 10, 4'b0010);
    push(r + 13, 4'b0100); push(r + 16, 4'b1000);
    wait_to(r + 6);
    speed_offset = 26'd7;
    wait_to(r + 17);
    chk("sb_empty_cut", sb_q.size(), 32'd0);

    // Trigger threshold, hit ignored in IDLE
    do_reset(26'd0, 10'd296, r);
    for (int c = r + 1; c <= r + 40; c++) begin
      wait_to(c);
      if (c == r + 1) chk("chase_296", 32'(chase), 32'd0);
      if (c == r + 5) hit = 4'b0001;
      if (c == r + 6) begin
        hit = 4'd0;
        chk("idle_hit", 32'(stunned), 32'd0);
      end
      if (c == r + 7) chk("idle_hit2", 32'(stunned), 32'd0);
      if (c == r + 10) chk("slot_t10", 32'(slot), 32'd1);
      if (c == r + 20) chk("slot_t20", 32'(slot), 32'd2);
      if (c == r + 30) chk("slot_t30", 32'(slot), 32'd3);
      if (c == r + 40) chk("slot_t40", 32'(slot), 32'd0);
      chk("anim_296", 32'(anim_sel), 32'd0);
    end
    jojo_y = 10'd297;
    push(r + 50, 4'b0001);
    wait_to(r + 41);
    chk("chase_297", 32'(chase), 32'hF);
    chk("anim_297", 32'(anim_sel), 32'd1);
    wait_to(r + 51);
    chk("sb_empty_trig", sb_q.size(), 32'd0);

    // Stun, suppression, restart with reload coinciding with a tick
    do_reset(26'd0, 10'd300, r);
    push(r + 10, 4'b0001); push(r + 20, 4'b0010); push(r + 40, 4'b1000);
    push(r + 50, 4'b0001); push(r + 60, 4'b0010); push(r + 80, 4'b1000);
    push(r + 90, 4'b0001);
    wait_to(r + 12); hit = 4'b0100;
    wait_to(r + 13); hit = 4'd0;
    chk("stun_on", 32'(stunned), 32'h4);
    chk("stun_chase", 32'(chase), 32'hB);
    wait_to(r + 39); chk("stun_hold", 32'(stunned), 32'h4);
    wait_to(r + 40); chk("stun_off", 32'(stunned), 32'd0);
    chk("stun_rechase", 32'(chase), 32'hF);
    wait_to(r + 42); hit = 4'b0100;
    wait_to(r + 43); hit = 4'd0;
    chk("stun2_on", 32'(stunned), 32'h4);
    wait_to(r + 59); hit = 4'b0100;
    wait_to(r + 60); hit = 4'd0;
    wait_to(r + 70); chk("stun2_reload", 32'(stunned), 32'h4);
    wait_to(r + 89); chk("stun2_hold", 32'(stunned), 32'h4);
    wait_to(r + 90); chk("stun2_off", 32'(stunned), 32'd0);
    wait_to(r + 95);
    chk("sb_empty_stun", sb_q.size(), 32'd0);

    // Hit wins over CHASE->IDLE; stun then expires into IDLE
    do_reset(26'd0, 10'd300, r);
    wait_to(r + 3); jojo_y = 10'd200; hit = 4'b0001;
    wait_to(r + 4); hit = 4'd0;
    chk("prio_stun", 32'(stunned), 32'h1);
    chk("prio_chase", 32'(chase), 32'd0);
    wait_to(r + 29); chk("prio_hold", 32'(stunned), 32'h1);
    wait_to(r + 30); chk("prio_off", 32'(stunned), 32'd0);
    chk("prio_idle", 32'(chase), 32'd0);
    wait_to(r + 31);

    // Pause mid-period for 25 cycles
    do_reset(26'd0, 10'd300, r);
    push(r + 10, 4'b0001); push(r + 45, 4'b0010); push(r + 55, 4'b0100);
    wait_to(r + 14);
    chk("pause_slot0", 32'(slot), 32'd1);
    pause = 1'b1;
    for (int c = r + 15; c <= r + 39; c++) begin
      wait_to(c);
      chk("pause_anim", 32'(anim_sel), 32'd1);
      chk("pause_slot", 32'(slot), 32'd1);
    end
    pause = 1'b0;
    wait_to(r + 45); chk("resume_slot", 32'(slot), 32'd2);
    wait_to(r + 56);
    chk("sb_empty_pause", sb_q.size(), 32'd0);

    // Reset asserted during a strobe
    do_reset(26'd0, 10'd300, r);
    wait_to(r + 9);
    sb_on = 1'b0;
    @(posedge clk);
    #2;
    chk("strobe_pre", 32'(move_en), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_move", 32'(move_en), 32'd0);
    chk("async_chase", 32'(chase), 32'd0);
    chk("async_stun", 32'(stunned), 32'd0);
    chk("async_slot", 32'(slot), 32'd0);
    @(negedge clk);
    do_reset(26'd0, 10'd300, r);
    push(r + 10, 4'b0001);
    wait_to(r + 11);
    chk("sb_empty_rel", sb_q.size(), 32'd0);

    sb_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
